// File: rtl/subinst_arb_pkg.sv
// Shared types, default sizes and the round-robin search helper for the level arbiters.
package subinst_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } arb_state_e;

    localparam int NUM_REQ_DFLT  = 15;
    localparam int MAX_HOLD_DFLT = 16;
    localparam int RR_MAX        = 64;

    // Returns {hit, index}. Offset n lands on ptr itself, so the previous owner ranks last.
    function automatic logic [6:0] rr_next(input logic [5:0]  ptr,
                                           input logic [63:0] req,
                                           input int          n = NUM_REQ_DFLT);
        logic [6:0] res;
        logic [5:0] j6;
        int         j;
        res = '0;
        for (int i = RR_MAX; i >= 1; i--) begin
            if (i <= n) begin
                j  = (int'(ptr) + i) % n;
                j6 = 6'(j);
                if (req[j6]) begin
                    res = {1'b1, j6};
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/subinst_rr_arbiter_rr_pick.sv
// Combinational rotate-priority find-first: first set req bit after ptr, wrapping.
module rr_pick
    import subinst_arb_pkg::*;
#(
    parameter int N  = NUM_REQ_DFLT,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          hit,
    output logic [IW-1:0] idx,
    output logic [N-1:0]  onehot
);

    logic [63:0] req_ext;
    logic [5:0]  ptr_ext;
    logic [6:0]  res;
    logic        unused_res;

    always_comb begin
        req_ext          = '0;
        req_ext[N-1:0]   = req;
        ptr_ext          = '0;
        ptr_ext[IW-1:0]  = ptr;
        res              = rr_next(ptr_ext, req_ext, N);
        hit              = res[6];
        idx              = res[IW-1:0];
        onehot           = '0;
        if (res[6]) begin
            onehot[idx] = 1'b1;
        end
    end

    assign unused_res = ^res;

endmodule

// File: rtl/subinst_rr_arbiter.sv
// Round-robin arbiter with one dead cycle between owners.
// Define SUBINST_ARB_TIMEOUT_EN to compile in the MAX_HOLD hold budget and timeout pulse.
module subinst_rr_arbiter
    import subinst_arb_pkg::*;
#(
    parameter int NUM_REQ  = NUM_REQ_DFLT,
    parameter int MAX_HOLD = MAX_HOLD_DFLT,
    parameter int ID_W     = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] rel,
    output logic [NUM_REQ-1:0] gnt,
    output logic               gnt_vld,
    output logic [ID_W-1:0]    gnt_id,
    output logic               timeout
);

    arb_state_e         state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic               gnt_vld_q, gnt_vld_d;
    logic [ID_W-1:0]    gnt_id_q, gnt_id_d;
    logic [ID_W-1:0]    last_q, last_d;
    logic               timeout_q, timeout_d;

    logic               pick_hit;
    logic [ID_W-1:0]    pick_idx;
    logic [NUM_REQ-1:0] pick_onehot;
    logic               own_rel, own_req, expire, do_grant;

`ifdef SUBINST_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(MAX_HOLD);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`else
    logic [31:0] unused_hold;
    assign unused_hold = 32'(MAX_HOLD);
`endif

    rr_pick #(.N(NUM_REQ), .IW(ID_W)) u_pick (
        .req    (req),
        .ptr    (last_q),
        .hit    (pick_hit),
        .idx    (pick_idx),
        .onehot (pick_onehot)
    );

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        gnt_vld_d = gnt_vld_q;
        gnt_id_d  = gnt_id_q;
        last_d    = last_q;
        timeout_d = 1'b0;
        own_rel   = rel[gnt_id_q];
        own_req   = req[gnt_id_q];
        do_grant  = 1'b0;
`ifdef SUBINST_ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
        expire    = (cnt_q == CNT_W'(MAX_HOLD - 1));
`else
        expire    = 1'b0;
`endif
        case (state_q)
            IDLE: do_grant = pick_hit;
            BUSY: begin
`ifdef SUBINST_ARB_TIMEOUT_EN
                cnt_d = cnt_q + 1'b1;
`endif
                if (own_rel || !own_req || expire) begin
                    state_d   = GAP;
                    gnt_d     = '0;
                    gnt_vld_d = 1'b0;
                    // A release or dropped request on the last cycle wins over expiry.
                    timeout_d = expire && own_req && !own_rel;
                end
            end
            GAP: begin
                do_grant = pick_hit;
                if (!pick_hit) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (do_grant) begin
            state_d   = BUSY;
            gnt_d     = pick_onehot;
            gnt_vld_d = 1'b1;
            gnt_id_d  = pick_idx;
            last_d    = pick_idx;
`ifdef SUBINST_ARB_TIMEOUT_EN
            cnt_d     = '0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            gnt_vld_q <= 1'b0;
            gnt_id_q  <= '0;
            last_q    <= ID_W'(NUM_REQ - 1);
            timeout_q <= 1'b0;
`ifdef SUBINST_ARB_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gnt_vld_q <= gnt_vld_d;
            gnt_id_q  <= gnt_id_d;
            last_q    <= last_d;
            timeout_q <= timeout_d;
`ifdef SUBINST_ARB_TIMEOUT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign gnt     = gnt_q;
    assign gnt_vld = gnt_vld_q;
    assign gnt_id  = gnt_id_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_subinst_rr_arbiter.sv
// Directed bench for subinst_rr_arbiter: vector table plus hold/timeout and reset sequences.
module tb_subinst_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [14:0] req;
    logic [14:0] rel;
    logic [14:0] gnt;
    logic        gnt_vld;
    logic [3:0]  gnt_id;
    logic        timeout;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [14:0] req;
        logic [14:0] rel;
        logic [14:0] gnt;
        logic        vld;
        logic [3:0]  id;
        logic        to;
    } vec_t;

    vec_t tbl[21];

    subinst_rr_arbiter #(.NUM_REQ(15), .MAX_HOLD(16)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .rel     (rel),
        .gnt     (gnt),
        .gnt_vld (gnt_vld),
        .gnt_id  (gnt_id),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [14:0] eg, input logic ev,
                           input logic [3:0] ei, input logic et);
        chk({tag, ".gnt"},     32'(gnt),     32'(eg));
        chk({tag, ".gnt_vld"}, 32'(gnt_vld), 32'(ev));
        chk({tag, ".gnt_id"},  32'(gnt_id),  32'(ei));
        chk({tag, ".timeout"}, 32'(timeout), 32'(et));
    endtask

    // Called at a falling edge: drive inputs, let one rising edge pass, return at the next fall.
    task automatic step(input logic [14:0] r, input logic [14:0] l);
        req = r;
        rel = l;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        tbl[0]  = '{15'h7FFF, 15'h0000, 15'h0001, 1'b1, 4'd0, 1'b0};
        tbl[1]  = '{15'h7FFF, 15'h0001, 15'h0000, 1'b0, 4'd0, 1'b0};
        tbl[2]  = '{15'h0003, 15'h0000, 15'h0002, 1'b1, 4'd1, 1'b0};
        tbl[3]  = '{15'h0003, 15'h0002, 15'h0000, 1'b0, 4'd1, 1'b0};
        tbl[4]  = '{15'h0003, 15'h0000, 15'h0001, 1'b1, 4'd0, 1'b0};
        tbl[5]  = '{15'h0003, 15'h0001, 15'h0000, 1'b0, 4'd0, 1'b0};
        tbl[6]  = '{15'h0003, 15'h0000, 15'h0002, 1'b1, 4'd1, 1'b0};
        tbl[7]  = '{15'h0003, 15'h0002, 15'h0000, 1'b0, 4'd1, 1'b0};
        tbl[8]  = '{15'h0004, 15'h0000, 15'h0004, 1'b1, 4'd2, 1'b0};
        tbl[9]  = '{15'h0004, 15'h0008, 15'h0004, 1'b1, 4'd2, 1'b0};
        tbl[10] = '{15'h000C, 15'h0000, 15'h0004, 1'b1, 4'd2, 1'b0};
        tbl[11] = '{15'h0008, 15'h0000, 15'h0000, 1'b0, 4'd2, 1'b0};
        tbl[12] = '{15'h0008, 15'h0000, 15'h0008, 1'b1, 4'd3, 1'b0};
        tbl[13] = '{15'h0000, 15'h0000, 15'h0000, 1'b0, 4'd3, 1'b0};
        tbl[14] = '{15'h0000, 15'h0000, 15'h0000, 1'b0, 4'd3, 1'b0};
        tbl[15] = '{15'h0000, 15'h0001, 15'h0000, 1'b0, 4'd3, 1'b0};
        tbl[16] = '{15'h0010, 15'h0000, 15'h0010, 1'b1, 4'd4, 1'b0};
        tbl[17] = '{15'h0010, 15'h0010, 15'h0000, 1'b0, 4'd4, 1'b0};
        tbl[18] = '{15'h0010, 15'h0000, 15'h0010, 1'b1, 4'd4, 1'b0};
        tbl[19] = '{15'h0000, 15'h0000, 15'h0000, 1'b0, 4'd4, 1'b0};
        tbl[20] = '{15'h0000, 15'h0000, 15'h0000, 1'b0, 4'd4, 1'b0};

        rst_n = 1'b0;
        req   = 15'h7FFF;
        rel   = 15'h0000;
        @(negedge clk);
        @(negedge clk);
        chk_all("reset", 15'h0000, 1'b0, 4'd0, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < 21; i++) begin
            step(tbl[i].req, tbl[i].rel);
            chk_all($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].vld, tbl[i].id, tbl[i].to);
        end

        // Sole requester 14 holding with no release.
        for (int i = 0; i < 16; i++) begin
            step(15'h4000, 15'h0000);
            chk_all($sformatf("hold14_c%0d", i), 15'h4000, 1'b1, 4'd14, 1'b0);
        end
`ifdef SUBINST_ARB_TIMEOUT_EN
        step(15'h4000, 15'h0000);
        chk_all("hold14_gap", 15'h0000, 1'b0, 4'd14, 1'b1);
        step(15'h4000, 15'h0000);
        chk_all("hold14_regrant", 15'h4000, 1'b1, 4'd14, 1'b0);
`else
        step(15'h4000, 15'h0000);
        chk_all("hold14_nolimit", 15'h4000, 1'b1, 4'd14, 1'b0);
`endif
        step(15'h0000, 15'h0000);
        chk_all("hold14_drop", 15'h0000, 1'b0, 4'd14, 1'b0);
        step(15'h0000, 15'h0000);
        chk_all("hold14_idle", 15'h0000, 1'b0, 4'd14, 1'b0);

        // Owner 5 releases on the cycle its budget runs out.
        step(15'h0020, 15'h0000);
        chk_all("own5_grant", 15'h0020, 1'b1, 4'd5, 1'b0);
        for (int i = 0; i < 15; i++) begin
            step(15'h0020, 15'h0000);
            chk_all($sformatf("own5_c%0d", i + 1), 15'h0020, 1'b1, 4'd5, 1'b0);
        end
        step(15'h0020, 15'h0020);
        chk_all("own5_rel_gap", 15'h0000, 1'b0, 4'd5, 1'b0);
        step(15'h0000, 15'h0000);
        chk_all("own5_idle", 15'h0000, 1'b0, 4'd5, 1'b0);

        // Asynchronous reset while slot 7 owns.
        step(15'h0080, 15'h0000);
        chk_all("own7_grant", 15'h0080, 1'b1, 4'd7, 1'b0);
        step(15'h0080, 15'h0000);
        chk_all("own7_hold", 15'h0080, 1'b1, 4'd7, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", 15'h0000, 1'b0, 4'd0, 1'b0);
        @(negedge clk);
        chk_all("rst_held", 15'h0000, 1'b0, 4'd0, 1'b0);
        rst_n = 1'b1;
        step(15'h0081, 15'h0000);
        chk_all("post_rst_slot0", 15'h0001, 1'b1, 4'd0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
